// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle MIPS control unit.
//   - FSM state encodings (state_t), IF is encoded as zero
//   - opcode / Func constants for the supported instruction subset
//   - ALUC operation codes, ALUSrcB and PCSrc mux select constants
//   - instruction class produced by the decoder
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EX_R   = 4'd2,
        S_WB_R   = 4'd3,
        S_EX_I   = 4'd4,
        S_WB_I   = 4'd5,
        S_EX_MEM = 4'd6,
        S_MEM_RD = 4'd7,
        S_WB_LD  = 4'd8,
        S_MEM_WR = 4'd9,
        S_BR     = 4'd10,
        S_JMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100,
        ALU_LUI = 3'b101
    } aluc_t;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        CL_R,
        CL_IMM,
        CL_MEM,
        CL_BR,
        CL_JMP,
        CL_ILL
    } iclass_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational instruction decoder.
//   op     in  : IR[31:26]
//   func   in  : IR[5:0]
//   iclass out : instruction class steering the FSM out of ID
//   se     out : extender select for the I-type execute step (1 = sign)
//   aluc   out : ALU operation for the execute step
//   legal  out : 1 when op/func is a supported instruction
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output iclass_t    iclass,
    output logic       se,
    output aluc_t      aluc,
    output logic       legal
);

    always_comb begin
        iclass = CL_ILL;
        se     = 1'b0;
        aluc   = ALU_ADD;
        legal  = 1'b0;
        case (op)
            OP_R: begin
                case (func)
                    FN_ADD:  begin aluc = ALU_ADD; legal = 1'b1; end
                    FN_SUB:  begin aluc = ALU_SUB; legal = 1'b1; end
                    FN_AND:  begin aluc = ALU_AND; legal = 1'b1; end
                    FN_OR:   begin aluc = ALU_OR;  legal = 1'b1; end
                    FN_SLT:  begin aluc = ALU_SLT; legal = 1'b1; end
                    default: ;
                endcase
                if (legal) iclass = CL_R;
            end
            OP_ADDI: begin iclass = CL_IMM; se = 1'b1; aluc = ALU_ADD; legal = 1'b1; end
            OP_ANDI: begin iclass = CL_IMM; aluc = ALU_AND; legal = 1'b1; end
            OP_ORI:  begin iclass = CL_IMM; aluc = ALU_OR;  legal = 1'b1; end
            OP_LUI:  begin iclass = CL_IMM; aluc = ALU_LUI; legal = 1'b1; end
            OP_LW, OP_SW: begin
                iclass = CL_MEM; se = 1'b1; aluc = ALU_ADD; legal = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                iclass = CL_BR; aluc = ALU_SUB; legal = 1'b1;
            end
            OP_J:    begin iclass = CL_JMP; legal = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle MIPS control FSM.
//   Clk, Reset (async, active-high), Op, Func, Z, MemReady in
//   PCWr, IRWr, IorD, MemWr, RegWr, RegDst, MemToReg, Se, ALUSrcA,
//   ALUSrcB[1:0], ALUC[2:0], PCSrc[1:0], Illegal, State[ST_W-1:0] out
// Optional macro MC_CTRL_MEMWAIT_EN: IF, MEM_RD and MEM_WR wait for MemReady.
// Outputs are decoded from State (plus Op/Func/Z) and forced to 0 in reset.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ST_W = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [5:0]      Op,
    input  logic [5:0]      Func,
    input  logic            Z,
    input  logic            MemReady,
    output logic            PCWr,
    output logic            IRWr,
    output logic            IorD,
    output logic            MemWr,
    output logic            RegWr,
    output logic            RegDst,
    output logic            MemToReg,
    output logic            Se,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [2:0]      ALUC,
    output logic [1:0]      PCSrc,
    output logic            Illegal,
    output logic [ST_W-1:0] State
);

    state_t  state, state_next;
    iclass_t dec_iclass;
    logic    dec_se, dec_legal;
    aluc_t   dec_aluc;

    mc_ctrl_decode u_decode (
        .op     (Op),
        .func   (Func),
        .iclass (dec_iclass),
        .se     (dec_se),
        .aluc   (dec_aluc),
        .legal  (dec_legal)
    );

`ifndef MC_CTRL_MEMWAIT_EN
    logic unused_mem_ready;
    assign unused_mem_ready = MemReady;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= S_IF;
        else       state <= state_next;
    end

    assign State = ST_W'(state);

    always_comb begin
        state_next = S_IF;
        PCWr       = 1'b0;
        IRWr       = 1'b0;
        IorD       = 1'b0;
        MemWr      = 1'b0;
        RegWr      = 1'b0;
        RegDst     = 1'b0;
        MemToReg   = 1'b0;
        Se         = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REGB;
        ALUC       = ALU_ADD;
        PCSrc      = PCSRC_ALU;
        Illegal    = 1'b0;
        if (!Reset) begin
            case (state)
                S_IF: begin
                    ALUSrcB = SRCB_FOUR;
`ifdef MC_CTRL_MEMWAIT_EN
                    PCWr       = MemReady;
                    IRWr       = MemReady;
                    state_next = MemReady ? S_ID : S_IF;
`else
                    PCWr       = 1'b1;
                    IRWr       = 1'b1;
                    state_next = S_ID;
`endif
                end
                S_ID: begin
                    ALUSrcB = SRCB_IMM_SH2;
                    Se      = 1'b1;
                    case (dec_iclass)
                        CL_R:    state_next = S_EX_R;
                        CL_IMM:  state_next = S_EX_I;
                        CL_MEM:  state_next = S_EX_MEM;
                        CL_BR:   state_next = S_BR;
                        CL_JMP:  state_next = S_JMP;
                        default: begin
                            state_next = S_IF;
                            Illegal    = 1'b1;
                        end
                    endcase
                end
                S_EX_R: begin
                    ALUSrcA    = 1'b1;
                    ALUC       = dec_aluc;
                    state_next = S_WB_R;
                end
                S_WB_R: begin
                    RegDst = 1'b1;
                    RegWr  = 1'b1;
                end
                S_EX_I: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = SRCB_IMM;
                    Se         = dec_se;
                    ALUC       = dec_aluc;
                    state_next = S_WB_I;
                end
                S_WB_I: RegWr = 1'b1;
                S_EX_MEM: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = SRCB_IMM;
                    Se         = 1'b1;
                    state_next = (Op == OP_LW) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    IorD = 1'b1;
`ifdef MC_CTRL_MEMWAIT_EN
                    state_next = MemReady ? S_WB_LD : S_MEM_RD;
`else
                    state_next = S_WB_LD;
`endif
                end
                S_WB_LD: begin
                    MemToReg = 1'b1;
                    RegWr    = 1'b1;
                end
                S_MEM_WR: begin
                    IorD  = 1'b1;
                    MemWr = 1'b1;
`ifdef MC_CTRL_MEMWAIT_EN
                    state_next = MemReady ? S_IF : S_MEM_WR;
`endif
                end
                S_BR: begin
                    ALUSrcA = 1'b1;
                    ALUC    = ALU_SUB;
                    PCSrc   = PCSRC_ALUOUT;
                    PCWr    = (Op == OP_BNE) ? ~Z : Z;
                end
                S_JMP: begin
                    PCSrc = PCSRC_JUMP;
                    PCWr  = 1'b1;
                end
                default: state_next = S_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: table-driven instruction sequences with a queue
// scoreboard, plus hand-written reset and memory-wait sequences.
module tb_mc_control_unit;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [5:0] Op, Func;
    logic       Z, MemReady;
    logic       PCWr, IRWr, IorD, MemWr, RegWr, RegDst, MemToReg, Se, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUC;
    logic       Illegal;
    logic [3:0] State;

    mc_control_unit #(.ST_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .Op(Op), .Func(Func), .Z(Z),
        .MemReady(MemReady), .PCWr(PCWr), .IRWr(IRWr), .IorD(IorD),
        .MemWr(MemWr), .RegWr(RegWr), .RegDst(RegDst), .MemToReg(MemToReg),
        .Se(Se), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUC(ALUC),
        .PCSrc(PCSrc), .Illegal(Illegal), .State(State)
    );

    always #5 Clk = ~Clk;

    localparam logic [3:0] T_IF = 4'd0, T_ID = 4'd1, T_EXR = 4'd2, T_WBR = 4'd3,
                           T_EXI = 4'd4, T_WBI = 4'd5, T_EXM = 4'd6, T_MRD = 4'd7,
                           T_WBL = 4'd8, T_MWR = 4'd9, T_BR = 4'd10, T_JMP = 4'd11;

    typedef struct packed {
        logic [3:0] state;
        logic pcwr, irwr, iord, memwr, regwr, regdst, memtoreg, se, alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluc;
        logic [1:0] pcsrc;
        logic illegal;
    } outs_t;

    typedef struct {
        string           name;
        logic [5:0]      op;
        logic [5:0]      fn;
        logic            z;
        int unsigned     len;
        logic [4:0][3:0] seq;
    } vec_t;

    vec_t  vq[$];
    outs_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic logic [4:0][3:0] sq(input logic [3:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    function automatic logic legal_ref(input logic [5:0] op, fn);
        if (op == 6'b000000)
            return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        return op inside {6'b000010, 6'b000100, 6'b000101, 6'b001000, 6'b001100,
                          6'b001101, 6'b001111, 6'b100011, 6'b101011};
    endfunction

    function automatic outs_t exp_out(input logic [3:0] st, input logic [5:0] op, fn,
                                      input logic z);
        outs_t e;
        e = '0;
        e.state = st;
        case (st)
            T_IF:  begin e.irwr = 1; e.pcwr = 1; e.alusrcb = 2'b01; end
            T_ID:  begin e.alusrcb = 2'b11; e.se = 1; e.illegal = !legal_ref(op, fn); end
            T_EXR: begin
                e.alusrca = 1;
                case (fn)
                    6'b100010: e.aluc = 3'b001;
                    6'b100100: e.aluc = 3'b010;
                    6'b100101: e.aluc = 3'b011;
                    6'b101010: e.aluc = 3'b100;
                    default:   e.aluc = 3'b000;
                endcase
            end
            T_WBR: begin e.regdst = 1; e.regwr = 1; end
            T_EXI: begin
                e.alusrca = 1; e.alusrcb = 2'b10;
                case (op)
                    6'b001000: begin e.se = 1; e.aluc = 3'b000; end
                    6'b001100: e.aluc = 3'b010;
                    6'b001101: e.aluc = 3'b011;
                    default:   e.aluc = 3'b101;
                endcase
            end
            T_WBI: e.regwr = 1;
            T_EXM: begin e.alusrca = 1; e.alusrcb = 2'b10; e.se = 1; end
            T_MRD: e.iord = 1;
            T_WBL: begin e.memtoreg = 1; e.regwr = 1; end
            T_MWR: begin e.iord = 1; e.memwr = 1; end
            T_BR:  begin
                e.alusrca = 1; e.aluc = 3'b001; e.pcsrc = 2'b01;
                e.pcwr = (op == 6'b000101) ? !z : z;
            end
            T_JMP: begin e.pcsrc = 2'b10; e.pcwr = 1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic outs_t got();
        outs_t g;
        g.state = State; g.pcwr = PCWr; g.irwr = IRWr; g.iord = IorD;
        g.memwr = MemWr; g.regwr = RegWr; g.regdst = RegDst;
        g.memtoreg = MemToReg; g.se = Se; g.alusrca = ALUSrcA;
        g.alusrcb = ALUSrcB; g.aluc = ALUC; g.pcsrc = PCSrc; g.illegal = Illegal;
        return g;
    endfunction

    task automatic check(input string nm);
        outs_t e, g;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = exp_q.pop_front();
            g = got();
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got=%h expected=%h (t=%0t)", nm, g, e, $time);
            end
        end
    endtask

    // Push an expectation, compare on the falling edge, move past the next rising edge.
    task automatic step(input outs_t e, input string nm);
        exp_q.push_back(e);
        @(negedge Clk);
        check(nm);
        @(posedge Clk);
        #1;
    endtask

    task automatic add_vec(input string nm, input logic [5:0] op, fn, input logic z,
                           input int unsigned len, input logic [4:0][3:0] seq);
        vec_t v;
        v.name = nm; v.op = op; v.fn = fn; v.z = z; v.len = len; v.seq = seq;
        vq.push_back(v);
    endtask

    outs_t e;

    initial begin
        add_vec("add",   6'h00, 6'b100000, 0, 4, sq(T_IF, T_ID, T_EXR, T_WBR, T_IF));
        add_vec("sub",   6'h00, 6'b100010, 1, 4, sq(T_IF, T_ID, T_EXR, T_WBR, T_IF));
        add_vec("and",   6'h00, 6'b100100, 0, 4, sq(T_IF, T_ID, T_EXR, T_WBR, T_IF));
        add_vec("or",    6'h00, 6'b100101, 0, 4, sq(T_IF, T_ID, T_EXR, T_WBR, T_IF));
        add_vec("slt",   6'h00, 6'b101010, 1, 4, sq(T_IF, T_ID, T_EXR, T_WBR, T_IF));
        add_vec("addi",  6'b001000, 6'h3f, 0, 4, sq(T_IF, T_ID, T_EXI, T_WBI, T_IF));
        add_vec("andi",  6'b001100, 6'h20, 0, 4, sq(T_IF, T_ID, T_EXI, T_WBI, T_IF));
        add_vec("ori",   6'b001101, 6'h00, 1, 4, sq(T_IF, T_ID, T_EXI, T_WBI, T_IF));
        add_vec("lui",   6'b001111, 6'h15, 0, 4, sq(T_IF, T_ID, T_EXI, T_WBI, T_IF));
        add_vec("lw",    6'b100011, 6'h00, 0, 5, sq(T_IF, T_ID, T_EXM, T_MRD, T_WBL));
        add_vec("sw",    6'b101011, 6'h00, 1, 4, sq(T_IF, T_ID, T_EXM, T_MWR, T_IF));
        add_vec("beq_z0", 6'b000100, 6'h00, 0, 3, sq(T_IF, T_ID, T_BR, T_IF, T_IF));
        add_vec("beq_z1", 6'b000100, 6'h00, 1, 3, sq(T_IF, T_ID, T_BR, T_IF, T_IF));
        add_vec("bne_z1", 6'b000101, 6'h00, 1, 3, sq(T_IF, T_ID, T_BR, T_IF, T_IF));
        add_vec("bne_z0", 6'b000101, 6'h00, 0, 3, sq(T_IF, T_ID, T_BR, T_IF, T_IF));
        add_vec("j",     6'b000010, 6'h00, 0, 3, sq(T_IF, T_ID, T_JMP, T_IF, T_IF));
        add_vec("ill_fn", 6'h00, 6'h00, 0, 2, sq(T_IF, T_ID, T_IF, T_IF, T_IF));
        add_vec("ill_op", 6'b111111, 6'h20, 0, 2, sq(T_IF, T_ID, T_IF, T_IF, T_IF));

        Reset = 1'b1; Op = '0; Func = '0; Z = 1'b0; MemReady = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        exp_q.push_back(outs_t'('0));
        check("reset_state");
        Reset = 1'b0;

        foreach (vq[i]) begin
            Op = vq[i].op; Func = vq[i].fn; Z = vq[i].z;
            for (int unsigned k = 0; k < vq[i].len; k++)
                step(exp_out(vq[i].seq[k], Op, Func, Z), vq[i].name);
        end

        // Reset in EX_R: outputs drop at once, the write-back never happens.
        Op = 6'h00; Func = 6'b100000; Z = 1'b0;
        step(exp_out(T_IF, Op, Func, Z), "rst_seq_if");
        step(exp_out(T_ID, Op, Func, Z), "rst_seq_id");
        exp_q.push_back(exp_out(T_EXR, Op, Func, Z));
        @(negedge Clk);
        check("rst_seq_exr");
        Reset = 1'b1;
        #1;
        exp_q.push_back(outs_t'('0));
        check("rst_async_zero");
        @(posedge Clk);
        #1;
        exp_q.push_back(outs_t'('0));
        check("rst_hold_zero");
        Reset = 1'b0;
        #1;
        exp_q.push_back(exp_out(T_IF, Op, Func, Z));
        check("rst_release_if");
        @(posedge Clk);
        #1;
        step(exp_out(T_ID, Op, Func, Z), "rst_after_id");
        step(exp_out(T_EXR, Op, Func, Z), "rst_after_exr");
        step(exp_out(T_WBR, Op, Func, Z), "rst_after_wbr");

        Op = 6'b101011; Func = '0;
`ifdef MC_CTRL_MEMWAIT_EN
        // IF stall, then MEM_WR held for three not-ready cycles.
        MemReady = 1'b0;
        e = exp_out(T_IF, Op, Func, Z);
        e.pcwr = 0; e.irwr = 0;
        step(e, "wait_if_hold");
        MemReady = 1'b1;
        step(exp_out(T_IF, Op, Func, Z), "wait_if_go");
        step(exp_out(T_ID, Op, Func, Z), "wait_id");
        step(exp_out(T_EXM, Op, Func, Z), "wait_exm");
        MemReady = 1'b0;
        for (int unsigned k = 0; k < 3; k++)
            step(exp_out(T_MWR, Op, Func, Z), "wait_mwr_hold");
        MemReady = 1'b1;
        step(exp_out(T_MWR, Op, Func, Z), "wait_mwr_done");
        step(exp_out(T_IF, Op, Func, Z), "wait_back_if");
`else
        // MemReady low has no effect in the default build.
        MemReady = 1'b0;
        step(exp_out(T_IF, Op, Func, Z), "nowait_if");
        step(exp_out(T_ID, Op, Func, Z), "nowait_id");
        step(exp_out(T_EXM, Op, Func, Z), "nowait_exm");
        step(exp_out(T_MWR, Op, Func, Z), "nowait_mwr");
        step(exp_out(T_IF, Op, Func, Z), "nowait_back_if");
        MemReady = 1'b1;
`endif

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got=%0d leftover expected=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle MIPS control FSM that sequences the shared datapath: PC, IR, register file, ALU, memory and the 16-to-32 immediate extender.
- Decodes Op/Func from the latched IR.
- Drives every mux select and write enable, including the extender sign/zero select Se, one instruction at a time.

Parameters:
- ST_W, 4, state register width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Op  in  6  IR[31:26].
- Func  in  6  IR[5:0].
- Z  in  1  ALU zero flag (combinational, current cycle).
- MemReady  in  1  memory done (used only with the optional feature).
- PCWr  out  1  PC write enable.
- IRWr  out  1  IR write enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWr  out  1  data memory write.
- RegWr  out  1  register file write.
- RegDst  out  1  destination select: 0 = rt, 1 = rd.
- MemToReg  out  1  write-back select: 0 = ALUOut, 1 = MDR.
- Se  out  1  extender select: 1 = sign-extend, 0 = zero-extend.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = regA.
- ALUSrcB  out  2  ALU B select: 00 regB, 01 const 4, 10 ext imm, 11 ext imm<<2.
- ALUC  out  3  ALU operation.
- PCSrc  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
- Illegal  out  1  one-cycle pulse on an undecodable instruction.
- State  out  ST_W  current state, for debug.

Behaviour:
- Clock and reset: one clock (Clk). Reset is asynchronous and active-high.
  - Reset forces State = IF.
  - While Reset is high, all outputs are 0.
  - Reset mid-instruction abandons it; no partial writes follow.
- Outputs are combinational from State, Op, Func and Z (Moore except branch PCWr). Unlisted outputs are 0 in each state.
- IF: IorD=0, IRWr=1, ALUSrcA=0, ALUSrcB=01, ALUC=add, PCSrc=00, PCWr=1. Next state: ID.
- ID: ALUSrcA=0, ALUSrcB=11, Se=1, ALUC=add (branch target into ALUOut). Next state by Op:
  - R-type with legal Func -> EX_R.
  - addi, andi, ori, lui -> EX_I.
  - lw, sw -> EX_MEM.
  - beq, bne -> BR.
  - j -> JMP.
  - Anything else -> IF with Illegal=1.
- EX_R: ALUSrcA=1, ALUSrcB=00, ALUC from Func. Next: WB_R.
- WB_R: RegDst=1, RegWr=1. Next: IF.
- EX_I: ALUSrcA=1, ALUSrcB=10.
  - addi: Se=1, add.
  - andi: Se=0, and.
  - ori: Se=0, or.
  - lui: Se=0, ALUC=lui.
  - Next: WB_I.
- WB_I: RegDst=0, RegWr=1. Next: IF.
- EX_MEM: ALUSrcA=1, ALUSrcB=10, Se=1, add. Next: MEM_RD for lw, MEM_WR for sw.
- MEM_RD: IorD=1. Next: WB_LD.
- WB_LD: MemToReg=1, RegDst=0, RegWr=1. Next: IF.
- MEM_WR: IorD=1, MemWr=1. Next: IF.
- BR: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01.
  - PCWr = Z for beq, ~Z for bne.
  - Next: IF.
- JMP: PCSrc=10, PCWr=1. Next: IF.
- CPI: R/I-type and sw 4 cycles, lw 5, beq/bne/j 3, illegal 2.
- Decode tables:
  - Opcodes: R 000000, j 000010, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, lui 001111, lw 100011, sw 101011.
  - Func: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- Unused state encodings go to IF.

Optional Feature:
- Macro: MC_CTRL_MEMWAIT_EN.
- Defined: IF, MEM_RD and MEM_WR hold while MemReady=0.
  - In IF, PCWr and IRWr are asserted only in the cycle MemReady=1.
  - In MEM_WR, MemWr stays high until MemReady=1.
  - In MEM_RD, the FSM advances only on MemReady=1.
- Undefined: MemReady is ignored; each of those states lasts one cycle.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings;
  - opcode and Func constants;
  - ALUC codes: add 000, sub 001, and 010, or 011, slt 100, lui 101;
  - ALUSrcB and PCSrc select constants.
- Sub-module mc_ctrl_decode: combinational Op/Func -> instruction class, Se value, ALUC and legal flag. The FSM instantiates it.

Test Plan:
- Reset asserted mid-EX_R then released -> all outputs 0 during reset; next cycle State=IF with PCWr=1, IRWr=1.
- Op=001100 (andi) -> sequence IF, ID, EX_I, WB_I; Se=0 and ALUC=010 in EX_I; RegWr=1 only in WB_I.
- Op=100011 (lw) -> 5 cycles; Se=1 in EX_MEM, IorD=1 in MEM_RD, MemToReg=1 and RegWr=1 in WB_LD.
- Op=000101 (bne): Z=1 -> PCWr=0 in BR; Z=0 -> PCWr=1 with PCSrc=01.
- Op=000000, Func=000000 -> Illegal pulses 1 cycle in ID; returns to IF; no RegWr or MemWr asserted.
- With MC_CTRL_MEMWAIT_EN, sw with MemReady low for 3 cycles -> MEM_WR held 4 cycles with MemWr=1 throughout, then IF.
